// File: rtl/fifo_pkg.sv
// Shared types and helpers for the replay FIFO and its pointer registers.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
    logic valid;
  } fifo_status_t;

  function automatic int fill_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Modulo increment that does not rely on depth being a power of two.
  function automatic int wrap_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer register; load takes priority over inc.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 24,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (load) begin
      ptr_next = load_val;
    end else if (inc) begin
      ptr_next = PW'(wrap_inc(int'(ptr_reg), DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/replay_fifo.sv
// Valid/ready FIFO with first-word-fall-through reads, any depth >= 2, and a
// circular replay mode that re-reads stored contents without popping them.
module replay_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 24,
  parameter int ALMOSTFULL  = 1,
  parameter int ALMOSTEMPTY = 1,
  localparam int FILLBITS   = fill_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                replay,
  input  logic                rewind,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [WIDTH-1:0]    rd_data,
  output logic [FILLBITS-1:0] fill_level,
  output logic                empty,
  output logic                almost_empty,
  output logic                full,
  output logic                almost_full,
  output logic                overflow
);

  localparam int PW     = $clog2(DEPTH);
  localparam int AE_INT = (ALMOSTEMPTY < DEPTH) ? ALMOSTEMPTY : DEPTH;
  localparam int AF_INT = (ALMOSTFULL < DEPTH) ? DEPTH - ALMOSTFULL : 0;
  localparam logic [FILLBITS-1:0] FILL_MAX = FILLBITS'(DEPTH);
  localparam logic [FILLBITS-1:0] AE_LIM   = FILLBITS'(AE_INT);
  localparam logic [FILLBITS-1:0] AF_LIM   = FILLBITS'(AF_INT);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]       head, tail, cursor;
  logic [PW-1:0]       head_inc, tail_inc, cursor_inc;
  logic [PW-1:0]       head_next, tail_next, cursor_load_val;
  logic                wr_acc, rd_hs, mode_edge, pop, replay_rd;
  logic                cursor_wrap, cursor_load;
  logic [FILLBITS-1:0] fill_reg, fill_next;
  fifo_status_t        status_reg, status_next;
  logic                overflow_reg, overflow_next;
  logic                replay_prev_reg;

  function automatic fifo_status_t status_of(input logic [FILLBITS-1:0] f);
    fifo_status_t s;
    s.empty        = (f == '0);
    s.almost_empty = (f <= AE_LIM);
    s.full         = (f == FILL_MAX);
    s.almost_full  = (f >= AF_LIM);
    s.valid        = (f != '0);
    return s;
  endfunction

  assign wr_ready  = !status_reg.full;
  assign rd_valid  = status_reg.valid;
  assign wr_acc    = wr_valid & wr_ready & !clear;
  assign rd_hs     = rd_valid & rd_ready & !clear;
  assign mode_edge = replay ^ replay_prev_reg;
  // A read during the mode-change cycle neither pops nor moves the cursor.
  assign pop       = rd_hs & !replay & !mode_edge;
  assign replay_rd = rd_hs & replay & !mode_edge;

  assign head_inc   = PW'(wrap_inc(int'(head), DEPTH));
  assign tail_inc   = PW'(wrap_inc(int'(tail), DEPTH));
  assign cursor_inc = PW'(wrap_inc(int'(cursor), DEPTH));
  assign head_next  = pop ? head_inc : head;
  assign tail_next  = wr_acc ? tail_inc : tail;

  // Compare against the post-write tail so a same-cycle write extends the window.
  assign cursor_wrap     = replay_rd & (cursor_inc == tail_next);
  assign cursor_load     = clear | !replay | mode_edge | rewind | cursor_wrap;
  assign cursor_load_val = clear ? '0 : head_next;

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (pop),
    .load     (clear),
    .load_val ('0),
    .ptr      (head)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (wr_acc),
    .load     (clear),
    .load_val ('0),
    .ptr      (tail)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_cursor_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (replay_rd),
    .load     (cursor_load),
    .load_val (cursor_load_val),
    .ptr      (cursor)
  );

  always_comb begin
    fill_next = fill_reg;
    if (clear) begin
      fill_next = '0;
    end else if (wr_acc && !pop) begin
      fill_next = fill_reg + 1'b1;
    end else if (!wr_acc && pop) begin
      fill_next = fill_reg - 1'b1;
    end
  end

  assign status_next   = status_of(fill_next);
  assign overflow_next = clear ? 1'b0 : (overflow_reg | (wr_valid & !wr_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_reg        <= '0;
      status_reg      <= '{empty: 1'b1, almost_empty: 1'b1, full: 1'b0,
                           almost_full: (AF_LIM == '0), valid: 1'b0};
      overflow_reg    <= 1'b0;
      replay_prev_reg <= 1'b0;
    end else begin
      fill_reg        <= fill_next;
      status_reg      <= status_next;
      overflow_reg    <= overflow_next;
      replay_prev_reg <= replay;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[tail] <= wr_data;
    end
  end

  assign rd_data      = rd_valid ? mem[cursor] : '0;
  assign fill_level   = fill_reg;
  assign empty        = status_reg.empty;
  assign almost_empty = status_reg.almost_empty;
  assign full         = status_reg.full;
  assign almost_full  = status_reg.almost_full;
  assign overflow     = overflow_reg;

endmodule
